serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_full_adder_cell.sv | 16 +
 rtl/serial_adder.sv | 126 ++++++++++++
 tb/tb_serial_adder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared FSM state encoding and default operand width for the bit-serial adder.
package serial_adder_pkg;

  localparam int unsigned SA_DEFAULT_WIDTH = 8;

  typedef logic [1:0] sa_state_t;

  localparam sa_state_t ST_IDLE = 2'b00;
  localparam sa_state_t ST_ADD  = 2'b01;
  localparam sa_state_t ST_DONE = 2'b10;

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// Single-bit combinational full adder used as the serial adder's only arithmetic cell.
module full_adder_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  logic w_axb;

  assign w_axb  = i_a ^ i_b;
  assign o_s    = w_axb ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & w_axb);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, WIDTH cycles per operation.
// Optional subtract mode enabled by defining SERIAL_ADDER_SUB_EN (adds port i_sub).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             i_sub,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_overflow
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  sa_state_t        r_state;
  sa_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic             r_carry;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [WIDTH-1:0] w_b_cap;
  logic             w_cin_cap;
  logic             w_fa_s;
  logic             w_fa_co;
  logic             w_last;

`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtract: invert B and force the carry-in.
  assign w_b_cap   = i_sub ? ~i_b : i_b;
  assign w_cin_cap = i_sub | i_cin;
`else
  assign w_b_cap   = i_b;
  assign w_cin_cap = i_cin;
`endif

  assign w_last = (r_cnt == LAST_CNT);

  full_adder_cell u_fa (
    .i_a    (r_opa[0]),
    .i_b    (r_opb[0]),
    .i_cin  (r_carry),
    .o_s    (w_fa_s),
    .o_cout (w_fa_co)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (i_start) w_state_nxt = ST_ADD;
      ST_ADD:  if (w_last)  w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = i_start ? ST_ADD : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_carry <= 1'b0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_opa   <= i_a;
            r_opb   <= w_b_cap;
            r_carry <= w_cin_cap;
            r_cnt   <= '0;
            r_acc   <= '0;
          end
        end
        ST_ADD: begin
          r_opa   <= r_opa >> 1;
          r_opb   <= r_opb >> 1;
          r_carry <= w_fa_co;
          r_acc   <= {w_fa_s, r_acc[WIDTH-1:1]};
          r_cnt   <= r_cnt + CNT_W'(1);
          // r_carry still holds the carry into the MSB on the final bit.
          if (w_last) begin
            r_sum  <= {w_fa_s, r_acc[WIDTH-1:1]};
            r_cout <= w_fa_co;
            r_ovf  <= r_carry ^ w_fa_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy     = (r_state == ST_ADD);
  assign o_done     = (r_state == ST_DONE);
  assign o_sum      = r_sum;
  assign o_cout     = r_cout;
  assign o_overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8; SERIAL_ADDER_SUB_EN adds a subtract vector.
module tb_serial_adder;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             i_start;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             i_sub;
`endif
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_sum;
  logic             o_cout;
  logic             o_overflow;

  int n_vec;
  int n_err;

  serial_adder #(.WIDTH(WIDTH)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (i_start),
    .i_a        (i_a),
    .i_b        (i_b),
    .i_cin      (i_cin),
`ifdef SERIAL_ADDER_SUB_EN
    .i_sub      (i_sub),
`endif
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_sum      (o_sum),
    .o_cout     (o_cout),
    .o_overflow (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered one falling edge after start was captured; counts falling edges until done.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!o_done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Entered and left at a falling edge.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic sub, input logic [7:0] exp_sum,
                        input logic exp_cout, input logic exp_ovf);
    int lat;
    i_start = 1'b1;
    i_a     = a;
    i_b     = b;
    i_cin   = c;
`ifdef SERIAL_ADDER_SUB_EN
    i_sub   = sub;
`else
    if (sub) $display("note: subtract vector requested without subtract support");
`endif
    @(negedge clk);
    i_start = 1'b0;
    i_a     = ~a;
    i_b     = ~b;
    i_cin   = ~c;
    check({tag, " busy"}, 64'(o_busy), 64'd1);
    wait_done(lat);
    check({tag, " latency"}, 64'(lat), 64'(WIDTH + 1));
    check({tag, " sum"}, 64'(o_sum), 64'(exp_sum));
    check({tag, " cout"}, 64'(o_cout), 64'(exp_cout));
    check({tag, " ovf"}, 64'(o_overflow), 64'(exp_ovf));
    check({tag, " busy at done"}, 64'(o_busy), 64'd0);
    @(negedge clk);
    check({tag, " done one cycle"}, 64'(o_done), 64'd0);
    check({tag, " sum held"}, 64'(o_sum), 64'(exp_sum));
  endtask

  initial begin
    int lat;
    int n_done;
    int done_at;
    logic [7:0] got_sum;

    n_vec   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    i_start = 1'b0;
    i_a     = '0;
    i_b     = '0;
    i_cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    i_sub   = 1'b0;
`endif

    repeat (2) @(negedge clk);
    check("reset busy", 64'(o_busy), 64'd0);
    check("reset done", 64'(o_done), 64'd0);
    check("reset sum", 64'(o_sum), 64'd0);
    check("reset cout", 64'(o_cout), 64'd0);
    check("reset ovf", 64'(o_overflow), 64'd0);

    // Start presented together with reset release: accepted on the first edge.
    rst_n = 1'b1;
    run_op("ff+01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Second start in ADD must be ignored.
    i_start = 1'b1; i_a = 8'h10; i_b = 8'h20; i_cin = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (2) @(negedge clk);
    i_start = 1'b1; i_a = 8'hAA;
    @(negedge clk);
    i_start = 1'b0;
    n_done  = 0;
    done_at = 0;
    got_sum = '0;
    for (int i = 4; i <= 24; i++) begin
      if (i > 4) @(negedge clk);
      if (o_done) begin
        n_done++;
        if (done_at == 0) begin
          done_at = i;
          got_sum = o_sum;
        end
      end
    end
    check("ignore done count", 64'(n_done), 64'd1);
    check("ignore done cycle", 64'(done_at), 64'd9);
    check("ignore sum", 64'(got_sum), 64'h31);

    // Back-to-back: start held in the DONE cycle.
    i_start = 1'b1; i_a = 8'h12; i_b = 8'h34; i_cin = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    wait_done(lat);
    check("b2b first latency", 64'(lat), 64'd9);
    check("b2b first sum", 64'(o_sum), 64'h46);
    i_start = 1'b1; i_a = 8'h80; i_b = 8'h80; i_cin = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    check("b2b direct to add", 64'(o_busy), 64'd1);
    wait_done(lat);
    check("b2b second spacing", 64'(lat), 64'd9);
    check("b2b second sum", 64'(o_sum), 64'h00);
    check("b2b second cout", 64'(o_cout), 64'd1);
    check("b2b second ovf", 64'(o_overflow), 64'd1);
    @(negedge clk);

    run_op("aa+55+1", 8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("7f+01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);

    // Reset in mid-operation aborts it and clears the result.
    i_start = 1'b1; i_a = 8'h12; i_b = 8'h34; i_cin = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort busy", 64'(o_busy), 64'd0);
    check("abort sum", 64'(o_sum), 64'd0);
    check("abort ovf", 64'(o_overflow), 64'd0);
    check("abort done", 64'(o_done), 64'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_done) n_done++;
    end
    check("abort no done", 64'(n_done), 64'd0);

    run_op("3c+c3", 8'h3C, 8'hC3, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
`ifdef SERIAL_ADDER_SUB_EN
    run_op("05-07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
